fir_tdf_param: RTL and testbench
================================

# fir_tdf_param

Parametrised transposed-direct-form FIR filter: the fixed-point, run-time-programmable successor of the fixed 8-tap filter. It uses signed two's-complement samples and coefficients, a runtime-writable coefficient bank, a sample-valid strobe, a synchronous flush, and a rounded, scaled output. It sits between the sample source and the downstream datapath: one sample in per `x_valid`, one filtered sample out one cycle later.

## Interface
- `TAPS`, default 8: number of taps, 2..64.
- `DW`, default 16: input sample width, signed.
- `CW`, default 16: coefficient width, signed.
- `OW`, default 16: output width, signed.
- `SHIFT`, default 15: arithmetic right shift applied to the accumulator, 0..DW+CW-1.
- `AW`, derived, not overridable: accumulator width, DW+CW+$clog2(TAPS).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low.
- `x`  in  DW  input sample.
- `x_valid`  in  1  sample strobe; the filter advances only when high.
- `flush`  in  1  synchronous clear of the delay line.
- `coef_we`  in  1  coefficient write enable.
- `coef_addr`  in  $clog2(TAPS)  tap index k.
- `coef_data`  in  CW  coefficient value c[k].
- `y`  out  OW  filtered sample, registered.
- `y_valid`  out  1  one-cycle pulse marking a new `y`.

## Operation
- Computes y[n] = scale(sum over k=0..TAPS-1 of c[k]·x[n-k]).
- Products are full DW+CW bits. Partial sums are sign-extended to AW, so no internal overflow is possible.
- Transposed delay line `r[1..TAPS-1]`, each AW bits. On a cycle with `x_valid`=1 and `flush`=0:
  - `r[TAPS-1]` ← c[TAPS-1]·x
  - `r[k]` ← c[k]·x + r[k+1], for 1≤k<TAPS-1
  - `acc` = c[0]·x + r[1] (combinational)
  - `y` ← scale(acc); `y_valid` ← 1
- On any other cycle, `r` holds and `y` holds; `y_valid` ← 0.
- Scale:
  - SHIFT>0: t = (acc + 2^(SHIFT-1)) >>> SHIFT, i.e. round half up.
  - SHIFT=0: t = acc.
  - Then t is reduced to OW bits per the Configuration section.
- Coefficient bank:
  - TAPS registers of CW bits.
  - On `coef_we`=1, c[`coef_addr`] ← `coef_data` at the clock edge.
  - Writes with `coef_addr` ≥ TAPS are ignored.
  - A write and `x_valid` in the same cycle: that sample uses the old value; the new value applies from the next sample.
- Flush:
  - `flush`=1 zeroes all `r[k]` and forces `y_valid` ← 0.
  - `y` holds its value; coefficients are unchanged.
  - Flush has priority over a simultaneous `x_valid`; that sample is dropped.
- Reset (`rst`=0, asynchronous, any time including mid-stream): all `r[k]`=0, all c[k]=0, `y`=0, `y_valid`=0. Operation resumes on the first edge after `rst` rises.

## Timing
- Latency: `y`/`y_valid` update on the edge that samples `x_valid`=1 and are visible the following cycle, i.e. 1 cycle.
- Throughput: one sample per cycle; `x_valid` may be high continuously.
- There is no backpressure. `y_valid` is a single-cycle pulse per accepted sample, and the consumer must capture it.
- The impulse response appears over TAPS accepted samples. Gaps in `x_valid` do not disturb the delay line.
- The critical path is one multiplier plus one AW-bit adder, followed by the scale logic to the `y` register. The block adds no internal pipelining.

## Configuration
- Macro: `FIR_TDF_SAT_EN`.
- Defined: t saturates to the OW range. Values above 2^(OW-1)-1 clamp to 2^(OW-1)-1; values below -2^(OW-1) clamp to -2^(OW-1).
- Undefined: t wraps. `y` = t[OW-1:0], with two's-complement truncation.
- Rounding, latency and all other behaviour are identical in both builds.

## Test plan
- **Impulse response:** TAPS=8, SHIFT=0, c[k]=k+1; feed x=1 then seven zeros, all `x_valid` → `y` = 1,2,3,4,5,6,7,8 on successive `y_valid` pulses, then 0.
- **Gapped input:** same setup, `x_valid` high every third cycle → same `y` sequence; `y_valid` pulses exactly one cycle after each strobe; `y` holds between pulses.
- **Rounding:** all c[k]=0 except c[0]=1, SHIFT=1.
  - x=3 → `y`=2 (acc 3, rounded up).
  - x=-3 → `y`=-1.
- **Overflow:** TAPS=8, DW=CW=OW=16, SHIFT=15, all c[k]=32767, x=32767 held for 8 samples.
  - With `FIR_TDF_SAT_EN`: 8th output = 32767.
  - Without: 8th output = -16 (t=262128 wrapped).
- **Flush and coefficient timing:**
  - Assert `flush` with `x_valid` mid-impulse-response → no `y_valid` that cycle; subsequent zero inputs give `y`=0.
  - Write c[0]=5 in the same cycle as x=1 → that sample uses the old c[0]; the next x=1 gives a c[0] term of 5.
- **Async reset mid-stream:** drop `rst` between clock edges while the delay line is nonzero → `y`=0 and `y_valid`=0 immediately. After release, an impulse produces all zeros because the coefficients were cleared.

Source files
------------

// File: rtl/fir_tdf_param.sv
// Transposed-direct-form FIR with a runtime coefficient bank, flush, and a rounded, scaled registered output.
// Define FIR_TDF_SAT_EN to saturate the scaled result to OW bits; otherwise it wraps.
module fir_tdf_param #(
  parameter int TAPS  = 8,
  parameter int DW    = 16,
  parameter int CW    = 16,
  parameter int OW    = 16,
  parameter int SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DW-1:0]      x,
  input  logic                      x_valid,
  input  logic                      flush,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [CW-1:0]      coef_data,
  output logic signed [OW-1:0]      y,
  output logic                      y_valid
);

  localparam int AB = $clog2(TAPS);
  localparam int PW = DW + CW;
  localparam int AW = DW + CW + $clog2(TAPS);
  localparam int TW = AW + 1;

  logic signed [CW-1:0] c  [TAPS];
  logic signed [PW-1:0] p  [TAPS];
  logic signed [AW-1:0] pe [TAPS];
  logic signed [AW-1:0] r  [1:TAPS-1];
  logic signed [AW-1:0] acc;
  logic signed [TW-1:0] acc_x;
  logic signed [TW-1:0] t;
  logic signed [OW-1:0] y_next;

  // Out-of-range addresses match no tap, so such writes are dropped naturally.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        c[k] <= '0;
      end else if (coef_we && coef_addr == AB'(k)) begin
        c[k] <= coef_data;
      end
    end

    assign p[k]  = c[k] * x;
    assign pe[k] = {{(AW-PW){p[k][PW-1]}}, p[k]};
  end

  assign acc   = pe[0] + r[1];
  assign acc_x = {acc[AW-1], acc};

  if (SHIFT > 0) begin : g_round
    localparam logic signed [TW-1:0] HALF = TW'(1) << (SHIFT - 1);
    logic signed [TW-1:0] rnd;
    assign rnd = acc_x + HALF;
    assign t   = rnd >>> SHIFT;
  end else begin : g_noround
    assign t = acc_x;
  end

`ifdef FIR_TDF_SAT_EN
  localparam logic signed [TW-1:0] SAT_MAX = (TW'(1) << (OW - 1)) - TW'(1);
  localparam logic signed [TW-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    y_next = t[OW-1:0];
    if (t > SAT_MAX) begin
      y_next = SAT_MAX[OW-1:0];
    end else if (t < SAT_MIN) begin
      y_next = SAT_MIN[OW-1:0];
    end
  end
`else
  logic unused_t_hi;
  assign unused_t_hi = ^t[TW-1:OW];
  assign y_next      = t[OW-1:0];
`endif

  // Flush wins over a simultaneous sample; that sample is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 1; k < TAPS; k++) r[k] <= '0;
      y       <= '0;
      y_valid <= 1'b0;
    end else if (flush) begin
      for (int k = 1; k < TAPS; k++) r[k] <= '0;
      y_valid <= 1'b0;
    end else if (x_valid) begin
      for (int k = 1; k < TAPS - 1; k++) r[k] <= pe[k] + r[k+1];
      r[TAPS-1] <= pe[TAPS-1];
      y         <= y_next;
      y_valid   <= 1'b1;
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tdf_param.sv
// Bench for fir_tdf_param: three instances (SHIFT 0, 1, 15) share one stimulus stream and are
// compared against a sample/coefficient-history model.
module tb_fir_tdf_param;
  localparam int TAPS = 8;
  localparam int DW   = 16;
  localparam int CW   = 16;
  localparam int OW   = 16;
  localparam int NDUT = 3;

  logic                 clk;
  logic                 rst;
  logic signed [DW-1:0] x;
  logic                 x_valid;
  logic                 flush;
  logic                 coef_we;
  logic [2:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic signed [OW-1:0] y0, y1, y2;
  logic                 v0, v1, v2;

  fir_tdf_param #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(0)) u_s0 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .flush(flush), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .y(y0), .y_valid(v0));
  fir_tdf_param #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(1)) u_s1 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .flush(flush), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .y(y1), .y_valid(v1));
  fir_tdf_param #(.TAPS(TAPS), .DW(DW), .CW(CW), .OW(OW), .SHIFT(15)) u_s15 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .flush(flush), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_data(coef_data), .y(y2), .y_valid(v2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // model state: each accepted sample remembers the coefficients in force when it arrived
  longint     m_coef [TAPS];
  longint     h_x    [TAPS];
  longint     h_c    [TAPS][TAPS];
  longint     exp_y  [NDUT];
  bit         exp_v;
  logic [OW-1:0] exp_q[$];
  int         n_checks;
  int         n_fail;

  function automatic int shift_of(input int d);
    case (d)
      0:       return 0;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic longint scale(input longint acc, input int s);
    longint t;
    logic [63:0] tb;
    logic signed [OW-1:0] w;
    if (s > 0) t = (acc + (longint'(1) <<< (s - 1))) >>> s;
    else       t = acc;
`ifdef FIR_TDF_SAT_EN
    if (t > 32767)  return 32767;
    if (t < -32768) return -32768;
    return t;
`else
    tb = t;
    w  = tb[OW-1:0];
    return longint'(w);
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      m_coef[k] = 0;
      h_x[k]    = 0;
      for (int j = 0; j < TAPS; j++) h_c[k][j] = 0;
    end
    for (int d = 0; d < NDUT; d++) exp_y[d] = 0;
    exp_v = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input longint xv, input bit xval, input bit fl, input bit we,
                            input int addr, input longint data);
    longint acc;
    logic [63:0] ybits;
    if (fl) begin
      for (int k = 0; k < TAPS; k++) h_x[k] = 0;
      exp_v = 1'b0;
    end else if (xval) begin
      for (int k = TAPS - 1; k > 0; k--) begin
        h_x[k] = h_x[k-1];
        for (int j = 0; j < TAPS; j++) h_c[k][j] = h_c[k-1][j];
      end
      h_x[0] = xv;
      for (int j = 0; j < TAPS; j++) h_c[0][j] = m_coef[j];
      acc = 0;
      for (int k = 0; k < TAPS; k++) acc += h_c[k][k] * h_x[k];
      for (int d = 0; d < NDUT; d++) exp_y[d] = scale(acc, shift_of(d));
      ybits = exp_y[2];
      exp_q.push_back(ybits[OW-1:0]);
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    if (we && addr < TAPS) m_coef[addr] = data;
  endtask

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [OW-1:0] q;
    check_eq("v_s0", v0, exp_v);
    check_eq("v_s1", v1, exp_v);
    check_eq("v_s15", v2, exp_v);
    check_eq("y_s0", y0, exp_y[0]);
    check_eq("y_s1", y1, exp_y[1]);
    if (v2) begin
      if (exp_q.size() > 0) begin
        q = exp_q.pop_front();
        check_eq("y_s15", y2, longint'($signed(q)));
      end else begin
        check_eq("q_underflow", v2, 0);
      end
    end
  endtask

  // driver: inputs change at the falling edge, outputs checked at the next falling edge
  task automatic drive(input logic signed [DW-1:0] xv, input bit xval, input bit fl,
                       input bit we, input int addr, input logic signed [CW-1:0] data);
    x         = xv;
    x_valid   = xval;
    flush     = fl;
    coef_we   = we;
    coef_addr = addr[2:0];
    coef_data = data;
    @(posedge clk);
    model_step(longint'(xv), xval, fl, we, addr, longint'(data));
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    drive('0, 1'b0, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < TAPS; k++) drive('0, 1'b0, 1'b0, 1'b1, k, CW'(k + 1));
  endtask

  initial begin
    logic signed [CW-1:0] rd;
    logic signed [DW-1:0] rx;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    x         = '0;
    x_valid   = 1'b0;
    flush     = 1'b0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("rst_y_s0", y0, 0);
    check_eq("rst_y_s15", y2, 0);
    check_eq("rst_v_s0", v0, 0);
    rst = 1'b1;

    // impulse response, continuous strobe
    load_ramp();
    for (int i = 0; i < TAPS + 1; i++) begin
      drive((i == 0) ? 16'sd1 : 16'sd0, 1'b1, 1'b0, 1'b0, 0, '0);
      check_eq("impulse", y0, (i < TAPS) ? i + 1 : 0);
    end

    // gapped strobe: y holds between pulses
    for (int i = 0; i < TAPS; i++) begin
      drive((i == 0) ? 16'sd1 : 16'sd0, 1'b1, 1'b0, 1'b0, 0, '0);
      check_eq("gap_y", y0, i + 1);
      check_eq("gap_pulse", v0, 1);
      idle();
      check_eq("gap_hold", y0, i + 1);
      check_eq("gap_nopulse", v0, 0);
      idle();
    end

    // rounding: only c[0]=1, SHIFT=1 instance
    for (int k = 0; k < TAPS; k++) drive('0, 1'b0, 1'b0, 1'b1, k, (k == 0) ? 16'sd1 : 16'sd0);
    drive('0, 1'b0, 1'b1, 1'b0, 0, '0);
    drive(16'sd3, 1'b1, 1'b0, 1'b0, 0, '0);
    check_eq("round_pos", y1, 2);
    drive(-16'sd3, 1'b1, 1'b0, 1'b0, 0, '0);
    check_eq("round_neg", y1, -1);

    // overflow on the SHIFT=15 instance
    for (int k = 0; k < TAPS; k++) drive('0, 1'b0, 1'b0, 1'b1, k, 16'sd32767);
    drive('0, 1'b0, 1'b1, 1'b0, 0, '0);
    for (int i = 0; i < TAPS; i++) drive(16'sd32767, 1'b1, 1'b0, 1'b0, 0, '0);
`ifdef FIR_TDF_SAT_EN
    check_eq("overflow", y2, 32767);
`else
    check_eq("overflow", y2, -16);
`endif

    // flush mid-response drops the sample and clears the line
    load_ramp();
    drive('0, 1'b0, 1'b1, 1'b0, 0, '0);
    for (int i = 0; i < 3; i++) begin
      drive((i == 0) ? 16'sd1 : 16'sd0, 1'b1, 1'b0, 1'b0, 0, '0);
      check_eq("pre_flush", y0, i + 1);
    end
    drive(16'sd0, 1'b1, 1'b1, 1'b0, 0, '0);
    check_eq("flush_v", v0, 0);
    check_eq("flush_hold", y0, 3);
    for (int i = 0; i < 3; i++) begin
      drive(16'sd0, 1'b1, 1'b0, 1'b0, 0, '0);
      check_eq("post_flush", y0, 0);
    end

    // coefficient write alongside a sample
    drive(16'sd1, 1'b1, 1'b0, 1'b1, 0, 16'sd5);
    check_eq("coef_old", y0, 1);
    drive(16'sd1, 1'b1, 1'b0, 1'b0, 0, '0);
    check_eq("coef_new", y0, 7);

    // randomized stream
    for (int i = 0; i < 600; i++) begin
      rx = DW'($urandom_range(0, 65535));
      rd = CW'($urandom_range(0, 65535));
      drive(rx, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, TAPS - 1), rd);
    end

    // asynchronous reset mid-stream
    load_ramp();
    for (int i = 0; i < 3; i++) drive(16'sd1000, 1'b1, 1'b0, 1'b0, 0, '0);
    idle();
    #2;
    rst = 1'b0;
    #1;
    check_eq("arst_y_s0", y0, 0);
    check_eq("arst_y_s1", y1, 0);
    check_eq("arst_y_s15", y2, 0);
    check_eq("arst_v_s0", v0, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < TAPS; i++) begin
      drive((i == 0) ? 16'sd1 : 16'sd0, 1'b1, 1'b0, 1'b0, 0, '0);
      check_eq("post_rst", y0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
